// File: rtl/param_rx_frame_writer.sv
// rtl/param_rx_frame_writer.sv - framed byte-stream parser writing 32-bit words into the parameter RX RAM
// Optional checksum byte: define PARAM_RX_CHECKSUM_EN.
module param_rx_frame_writer #(
  parameter int          ADDR_W      = 11,
  parameter int          MAX_WORDS   = 1025,
  parameter int          TIMEOUT_CYC = 65535,
  parameter logic [7:0]  SOF_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] word_count
);

  typedef enum logic [2:0] {S_IDLE, S_AH, S_AL, S_LEN, S_DATA, S_WR, S_CHK} state_t;

  localparam logic [16:0] MAX_L    = 17'(MAX_WORDS);
  localparam logic [15:0] GAP_LAST = 16'(TIMEOUT_CYC - 1);

  state_t              state_q, state_d;
  logic                rx_ready_q, rx_ready_d;
  logic [15:0]         addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          idx_q, idx_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [31:0]         word_q, word_d;
  logic [15:0]         gap_q, gap_d;
  logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
  logic [3:0]          ram_byteenable_q, ram_byteenable_d;
  logic                ram_chipselect_q, ram_chipselect_d;
  logic                ram_write_q, ram_write_d;
  logic [31:0]         ram_writedata_q, ram_writedata_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_err_q, frame_err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [ADDR_W-1:0]   word_count_q, word_count_d;

  logic                accept;
  logic [16:0]         end_sum;
  logic [15:0]         wr_addr;
  logic [7:0]          idx_inc;
  logic [ADDR_W-1:0]   idx_ext;

  assign accept  = rx_valid & rx_ready_q;
  assign end_sum = {1'b0, addr_q} + {9'd0, rx_data};
  assign wr_addr = addr_q + {8'd0, idx_q};
  assign idx_inc = idx_q + 8'd1;
  assign idx_ext = {{(ADDR_W-8){1'b0}}, idx_q};

`ifdef PARAM_RX_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] chk_total;
  assign chk_total = sum_q + rx_data;

  always_comb begin
    sum_d = sum_q;
    if (state_q == S_IDLE)
      sum_d = 8'd0;
    else if (accept && (state_q == S_AH || state_q == S_AL || state_q == S_LEN || state_q == S_DATA))
      sum_d = sum_q + rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sum_q <= 8'd0;
    else          sum_q <= sum_d;
  end
`endif

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    len_d            = len_q;
    idx_d            = idx_q;
    bcnt_d           = bcnt_q;
    word_d           = word_q;
    gap_d            = gap_q;
    ram_address_d    = '0;
    ram_byteenable_d = 4'h0;
    ram_chipselect_d = 1'b0;
    ram_write_d      = 1'b0;
    ram_writedata_d  = 32'd0;
    frame_done_d     = 1'b0;
    frame_err_d      = 1'b0;
    err_code_d       = err_code_q;
    word_count_d     = word_count_q;

    case (state_q)
      S_IDLE: begin
        idx_d  = 8'd0;
        bcnt_d = 2'd0;
        if (accept && rx_data == SOF_BYTE) state_d = S_AH;
      end
      S_AH: if (accept) begin
        addr_d[15:8] = rx_data;
        state_d      = S_AL;
      end
      S_AL: if (accept) begin
        addr_d[7:0] = rx_data;
        state_d     = S_LEN;
      end
      S_LEN: if (accept) begin
        len_d = rx_data;
        // 17-bit sum so a high address cannot wrap back into range
        if (rx_data == 8'd0 || end_sum > MAX_L) begin
          frame_err_d  = 1'b1;
          err_code_d   = 2'd2;
          word_count_d = '0;
          state_d      = S_IDLE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: if (accept) begin
        word_d = {rx_data, word_q[31:8]};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          state_d          = S_WR;
          ram_address_d    = wr_addr[ADDR_W-1:0];
          ram_byteenable_d = 4'hF;
          ram_chipselect_d = 1'b1;
          ram_write_d      = 1'b1;
          ram_writedata_d  = {rx_data, word_q[31:8]};
        end
      end
      S_WR: begin
        idx_d = idx_inc;
        if (idx_inc == len_q) begin
`ifdef PARAM_RX_CHECKSUM_EN
          state_d = S_CHK;
`else
          frame_done_d = 1'b1;
          err_code_d   = 2'd0;
          word_count_d = {{(ADDR_W-8){1'b0}}, idx_inc};
          state_d      = S_IDLE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef PARAM_RX_CHECKSUM_EN
      S_CHK: if (accept) begin
        word_count_d = idx_ext;
        if (chk_total == 8'd0) begin
          frame_done_d = 1'b1;
          err_code_d   = 2'd0;
        end else begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd1;
        end
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Inter-byte gap watchdog; overrides the case only when no byte arrived
    if (state_q == S_IDLE || state_q == S_WR) begin
      gap_d = 16'd0;
    end else if (accept) begin
      gap_d = 16'd0;
    end else if (gap_q == GAP_LAST) begin
      gap_d        = 16'd0;
      frame_err_d  = 1'b1;
      err_code_d   = 2'd3;
      word_count_d = idx_ext;
      state_d      = S_IDLE;
    end else begin
      gap_d = gap_q + 16'd1;
    end

    busy_d     = (state_d != S_IDLE);
    rx_ready_d = (state_d != S_WR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      rx_ready_q       <= 1'b0;
      addr_q           <= 16'd0;
      len_q            <= 8'd0;
      idx_q            <= 8'd0;
      bcnt_q           <= 2'd0;
      word_q           <= 32'd0;
      gap_q            <= 16'd0;
      ram_address_q    <= '0;
      ram_byteenable_q <= 4'h0;
      ram_chipselect_q <= 1'b0;
      ram_write_q      <= 1'b0;
      ram_writedata_q  <= 32'd0;
      busy_q           <= 1'b0;
      frame_done_q     <= 1'b0;
      frame_err_q      <= 1'b0;
      err_code_q       <= 2'd0;
      word_count_q     <= '0;
    end else begin
      state_q          <= state_d;
      rx_ready_q       <= rx_ready_d;
      addr_q           <= addr_d;
      len_q            <= len_d;
      idx_q            <= idx_d;
      bcnt_q           <= bcnt_d;
      word_q           <= word_d;
      gap_q            <= gap_d;
      ram_address_q    <= ram_address_d;
      ram_byteenable_q <= ram_byteenable_d;
      ram_chipselect_q <= ram_chipselect_d;
      ram_write_q      <= ram_write_d;
      ram_writedata_q  <= ram_writedata_d;
      busy_q           <= busy_d;
      frame_done_q     <= frame_done_d;
      frame_err_q      <= frame_err_d;
      err_code_q       <= err_code_d;
      word_count_q     <= word_count_d;
    end
  end

  assign rx_ready       = rx_ready_q;
  assign ram_address    = ram_address_q;
  assign ram_byteenable = ram_byteenable_q;
  assign ram_chipselect = ram_chipselect_q;
  assign ram_write      = ram_write_q;
  assign ram_writedata  = ram_writedata_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;
  assign frame_err      = frame_err_q;
  assign err_code       = err_code_q;
  assign word_count     = word_count_q;

endmodule

// File: tb/tb_param_rx_frame_writer.sv
// tb/tb_param_rx_frame_writer.sv - scoreboarded, table-driven bench for param_rx_frame_writer
module tb_param_rx_frame_writer;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [10:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic        busy;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [10:0] word_count;

  param_rx_frame_writer #(.ADDR_W(11), .MAX_WORDS(1025), .TIMEOUT_CYC(TO), .SOF_BYTE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .busy(busy), .frame_done(frame_done),
    .frame_err(frame_err), .err_code(err_code), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          len;
    logic [7:0]  seed;
    logic [7:0]  delta;
    logic [1:0]  code;
  } vec_t;
  typedef struct { logic [10:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [1:0] code; logic [10:0] wc; } st_t;

  wr_t        wq[$];
  st_t        sq[$];
  logic [7:0] fb[$];
  vec_t       vecs[8];
  int         tests = 0;
  int         fails = 0;
  bit         chk_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pb(input logic [7:0] seed, input int k);
    int v;
    v = 8'h11 * (k + 1) + int'(seed);
    return v[7:0];
  endfunction

  function automatic logic [1:0] exp_code(input logic [15:0] addr, input int len, input logic [7:0] delta);
    if (len == 0 || int'(addr) + len > 1025) return 2'd2;
`ifdef PARAM_RX_CHECKSUM_EN
    if (delta != 8'd0) return 2'd1;
`endif
    return 2'd0;
  endfunction

  // Scoreboard monitor: compares RAM writes and status pulses against the queues
  always @(negedge clk) begin
    if (reset_n) begin
      if (ram_write) begin
        if (wq.size() == 0) check("unexpected_write", 32'(ram_address), 32'hFFFF_FFFF);
        else begin
          wr_t w;
          w = wq.pop_front();
          check("wr_addr", 32'(ram_address), 32'(w.a));
          check("wr_data", ram_writedata, w.d);
          check("wr_be", 32'(ram_byteenable), 32'hF);
          check("wr_cs", 32'(ram_chipselect), 32'h1);
        end
      end
      if (frame_done || frame_err) begin
        if (sq.size() == 0) check("unexpected_status", {30'd0, frame_err, frame_done}, 32'd0);
        else begin
          st_t s;
          s = sq.pop_front();
          check("st_done", 32'(frame_done), 32'(s.code == 2'd0));
          check("st_err", 32'(frame_err), 32'(s.code != 2'd0));
          check("st_code", 32'(err_code), 32'(s.code));
          check("st_wc", 32'(word_count), 32'(s.wc));
          check("st_busy", 32'(busy), 32'd0);
        end
      end
      if (chk_rdy) check("rdy_only_wr", 32'(rx_ready), 32'(!ram_write));
    end
  end

  // Builds byte list for a frame and queues the expected writes and status
  task automatic build(input vec_t v);
    logic [7:0] sum;
    logic [7:0] b;
    logic [31:0] word;
    fb.delete();
    fb.push_back(8'hA5);
    fb.push_back(v.addr[15:8]);
    fb.push_back(v.addr[7:0]);
    fb.push_back(8'(v.len));
    sum = v.addr[15:8] + v.addr[7:0] + 8'(v.len);
    if (v.code == 2'd2) begin
      sq.push_back('{code: 2'd2, wc: 11'd0});
    end else begin
      for (int w = 0; w < v.len; w++) begin
        word = 32'd0;
        for (int k = 0; k < 4; k++) begin
          b = pb(v.seed, w * 4 + k);
          word[8*k +: 8] = b;
          fb.push_back(b);
          sum = sum + b;
        end
        wq.push_back('{a: 11'(int'(v.addr) + w), d: word});
      end
`ifdef PARAM_RX_CHECKSUM_EN
      fb.push_back(8'(8'd0 - sum) + v.delta);
`endif
      sq.push_back('{code: v.code, wc: 11'(v.len)});
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int t;
    t = 0;
    if (rnd) while ($urandom_range(0, 2) == 0) begin rx_valid = 1'b0; @(negedge clk); end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input vec_t v, input bit rnd);
    build(v);
    for (int i = 0; i < fb.size(); i++) send_byte(fb[i], rnd);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((sq.size() != 0 || wq.size() != 0) && t < 40) begin @(negedge clk); t++; end
    check({name, "_status_left"}, 32'(sq.size()), 32'd0);
    check({name, "_writes_left"}, 32'(wq.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_pulses"}, {30'd0, frame_done, frame_err}, 32'd0);
    check({name, "_err_code"}, 32'(err_code), 32'd0);
    check({name, "_word_count"}, 32'(word_count), 32'd0);
    check({name, "_ram"}, {ram_write, ram_chipselect, ram_byteenable, 15'(ram_address)}, 32'd0);
    check({name, "_wdata"}, ram_writedata, 32'd0);
  endtask

  initial begin
    vec_t v;
    logic [7:0] s;
    vecs[0] = '{16'h0010, 2, 8'h00, 8'h00, 2'd0};
    vecs[1] = '{16'h0010, 2, 8'h00, 8'h55, 2'd0};
    vecs[2] = '{16'h0400, 2, 8'h00, 8'h00, 2'd0};
    vecs[3] = '{16'h0000, 0, 8'h00, 8'h00, 2'd0};
    vecs[4] = '{16'h03FF, 2, 8'h21, 8'h00, 2'd0};
    vecs[5] = '{16'h0400, 1, 8'h42, 8'h00, 2'd0};
    vecs[6] = '{16'hFFFF, 1, 8'h00, 8'h00, 2'd0};
    vecs[7] = '{16'h0005, 3, 8'h07, 8'h00, 2'd0};
    for (int i = 0; i < 8; i++) vecs[i].code = exp_code(vecs[i].addr, vecs[i].len, vecs[i].delta);

    reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(rx_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i], 1'b0);
      drain($sformatf("vec%0d", i));
    end

    // Range error: status pulse on the cycle right after LEN
    v = vecs[2];
    build(v);
    for (int i = 0; i < 4; i++) send_byte(fb[i], 1'b0);
    check("range_err_timing", 32'(frame_err), 32'd1);
    drain("range_dir");

    // Write latency and completion timing
    v = '{16'h0030, 1, 8'h09, 8'h00, 2'd0};
    build(v);
    for (int i = 0; i < 8; i++) send_byte(fb[i], 1'b0);
    check("wr_at_n1", 32'(ram_write), 32'd1);
    check("rdy_low_wr", 32'(rx_ready), 32'd0);
    @(negedge clk);
    check("rdy_at_n2", 32'(rx_ready), 32'd1);
`ifdef PARAM_RX_CHECKSUM_EN
    check("busy_before_chk", 32'(busy), 32'd1);
    send_byte(fb[8], 1'b0);
`endif
    check("done_timing", 32'(frame_done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    drain("latency");

    // Timeout mid-word
    sq.push_back('{code: 2'd3, wc: 11'd0});
    send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0); send_byte(8'h11, 1'b0);
    repeat (TO - 4) @(negedge clk);
    check("timeout_not_early", 32'(sq.size()), 32'd1);
    check("timeout_busy_held", 32'(busy), 32'd1);
    drain("timeout");
    check("timeout_code_held", 32'(err_code), 32'd3);
    send_frame(vecs[7], 1'b0);
    drain("after_timeout");

    // Garbage then a one-word frame under random backpressure
    chk_rdy = 1'b1;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_frame('{16'h0123, 1, 8'h5A, 8'h00, 2'd0}, 1'b1);
    drain("garbage");
    chk_rdy = 1'b0;

    // Reset after six payload bytes: first word lands, no status
    send_frame(vecs[2], 1'b0);
    drain("pre_reset");
    v = '{16'h0020, 3, 8'h03, 8'h00, 2'd0};
    s = 8'h00;
    send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h03, 1'b0);
    wq.push_back('{a: 11'h020, d: {pb(v.seed, 3), pb(v.seed, 2), pb(v.seed, 1), pb(v.seed, 0)}});
    for (int k = 0; k < 6; k++) send_byte(pb(v.seed, k), 1'b0);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (3) @(negedge clk);
    check("midreset_write_seen", 32'(wq.size()), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_midreset", 32'(rx_ready), 32'd1);
    send_frame(vecs[0], 1'b0);
    drain("after_midreset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
